// File: rtl/sub_layer_join_ctrl.sv
// Joins two independent valid/ready word streams into lock-step pairs for sub_layer, with frame sequencing.
// Optional feature macro: SUB_JOIN_PERF_EN adds a saturating stall-cycle counter on stall_cnt_o.
module sub_layer_join_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid1_i,
  output logic                        ready1_o,
  input  logic signed [WORD_SIZE-1:0] data1_i,
  input  logic                        valid2_i,
  output logic                        ready2_o,
  input  logic signed [WORD_SIZE-1:0] data2_i,
  output logic [1:0]                  valid_o,
  input  logic                        ready_i,
  output logic signed [WORD_SIZE-1:0] data1_r_o,
  output logic signed [WORD_SIZE-1:0] data2_r_o,
  output logic                        last_o,
  output logic                        frame_done_o,
  output logic                        busy_o
`ifdef SUB_JOIN_PERF_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {eIDLE, eRUN, eDONE} state_e;

  state_e        state_q;
  logic [CW-1:0] pair_cnt_q;

  logic [1:0]                in_valid;
  logic [1:0]                push;
  logic [1:0]                full;
  logic [1:0]                nonempty;
  logic [1:0]                nonempty_d;
  logic [1:0][WORD_SIZE-1:0] din;
  logic [1:0][WORD_SIZE-1:0] head;
  logic                      pair_ok;
  logic                      pop;
  logic                      last_pair;

  assign in_valid = {valid2_i, valid1_i};
  assign din      = {data2_i, data1_i};

  // Side 0 feeds the minuend, side 1 the subtrahend; both sides pop together.
  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [OW-1:0]        cnt_q;
    logic [OW-1:0]        cnt_d;

    assign full[gi]       = (cnt_q == OW'(FIFO_DEPTH));
    assign nonempty[gi]   = (cnt_q != '0);
    assign nonempty_d[gi] = (cnt_d != '0);
    assign push[gi]       = in_valid[gi] && !full[gi] && !reset_i;
    assign head[gi]       = mem_q[rd_ptr_q];

    always_comb begin
      cnt_d = cnt_q;
      if (push[gi] && !pop) begin
        cnt_d = cnt_q + OW'(1);
      end else if (!push[gi] && pop) begin
        cnt_d = cnt_q - OW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[gi]) begin
        mem_q[wr_ptr_q] <= din[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[gi]) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        cnt_q <= cnt_d;
      end
    end
  end

  assign pair_ok   = (state_q == eRUN) && (&nonempty) && !reset_i;
  assign pop       = pair_ok && ready_i;
  assign last_pair = pair_ok && (pair_cnt_q == CW'(FRAME_LEN - 1));

  // Looking at next-state occupancy lets a word written at one edge show up right after it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eIDLE;
      pair_cnt_q <= '0;
    end else begin
      case (state_q)
        eIDLE: begin
          if (&nonempty_d) begin
            state_q <= eRUN;
          end
        end
        eRUN: begin
          if (pop) begin
            if (last_pair) begin
              pair_cnt_q <= '0;
              state_q    <= eDONE;
            end else begin
              pair_cnt_q <= pair_cnt_q + CW'(1);
            end
          end
        end
        eDONE:   state_q <= eIDLE;
        default: state_q <= eIDLE;
      endcase
    end
  end

  assign valid_o      = {2{pair_ok}};
  assign last_o       = last_pair;
  assign frame_done_o = (state_q == eDONE) && !reset_i;
  assign busy_o       = (state_q != eIDLE) || (|nonempty);
  assign ready1_o     = !full[0] && !reset_i;
  assign ready2_o     = !full[1] && !reset_i;
  assign data1_r_o    = head[0];
  assign data2_r_o    = head[1];

`ifdef SUB_JOIN_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if (pair_ok && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sub_layer_join_ctrl.sv
// Bench for sub_layer_join_ctrl: scoreboard of accepted words plus table-driven frame and pattern checks.
// Builds with or without SUB_JOIN_PERF_EN.
module tb_sub_layer_join_ctrl;
  localparam int W  = 16;
  localparam int FL = 5;

  typedef struct packed {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         last;
  } pair_t;

  typedef struct packed {
    logic [1:0]   vo;
    logic         last;
    logic         done;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
  } pat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i = 1'b1;
  logic         v1 = 1'b0, v2 = 1'b0, rdy = 1'b0;
  logic [W-1:0] d1 = '0, d2 = '0;
  logic         r1, r2, last, done, busy;
  logic [1:0]   vo;
  logic [W-1:0] q1d, q2d;

  logic         b_v1 = 1'b0, b_v2 = 1'b0, b_rdy = 1'b0;
  logic [W-1:0] b_d1 = '0, b_d2 = '0;
  logic         b_r1, b_r2, b_last, b_done, b_busy;
  logic [1:0]   b_vo;
  logic [W-1:0] b_q1d, b_q2d;
`ifdef SUB_JOIN_PERF_EN
  logic [31:0]  stall_cnt, b_stall;
`endif

  sub_layer_join_ctrl #(.WORD_SIZE(W), .FIFO_DEPTH(4), .FRAME_LEN(FL)) u_dut (
    .clk_i(clk), .reset_i(reset_i),
    .valid1_i(v1), .ready1_o(r1), .data1_i(d1),
    .valid2_i(v2), .ready2_o(r2), .data2_i(d2),
    .valid_o(vo), .ready_i(rdy), .data1_r_o(q1d), .data2_r_o(q2d),
    .last_o(last), .frame_done_o(done), .busy_o(busy)
`ifdef SUB_JOIN_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  sub_layer_join_ctrl #(.WORD_SIZE(W), .FIFO_DEPTH(4), .FRAME_LEN(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset_i),
    .valid1_i(b_v1), .ready1_o(b_r1), .data1_i(b_d1),
    .valid2_i(b_v2), .ready2_o(b_r2), .data2_i(b_d2),
    .valid_o(b_vo), .ready_i(b_rdy), .data1_r_o(b_q1d), .data2_r_o(b_q2d),
    .last_o(b_last), .frame_done_o(b_done), .busy_o(b_busy)
`ifdef SUB_JOIN_PERF_EN
    , .stall_cnt_o(b_stall)
`endif
  );

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb1[$];
  logic [W-1:0] sb2[$];
  int           pidx = 0;
  int           xfers = 0;
  logic         exp_done = 1'b0;
  pair_t        frame_vec [5];
  pat_t         pat_vec [6];
  logic [W-1:0] pre1 [4];
  logic [W-1:0] pre2 [4];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for u_dut: records accepted words, checks every transfer and the done pulse.
  task automatic monitor();
    logic [W-1:0] e1, e2;
    logic         nd;
    nd = 1'b0;
    if (reset_i) begin
      sb1.delete();
      sb2.delete();
      pidx = 0;
      exp_done = 1'b0;
      return;
    end
    check("frame_done", done, exp_done);
    if (exp_done) check("done_valid", vo, 2'b00);
    check("valid_enc", (vo == 2'b00 || vo == 2'b11), 1);
    if (vo == 2'b11 && rdy) begin
      check("sb_nonempty", (sb1.size() > 0 && sb2.size() > 0), 1);
      if (sb1.size() > 0 && sb2.size() > 0) begin
        e1 = sb1.pop_front();
        e2 = sb2.pop_front();
        check("xfer_d1", q1d, e1);
        check("xfer_d2", q2d, e2);
        check("xfer_last", last, (pidx == FL - 1));
        $display("xfer %0d: d1=%h d2=%h last=%0b", xfers, q1d, q2d, last);
        nd = (pidx == FL - 1);
        pidx = nd ? 0 : pidx + 1;
        xfers++;
      end
    end
    if (v1 && r1) sb1.push_back(d1);
    if (v2 && r2) sb2.push_back(d2);
    exp_done = nd;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset_i = 1'b1;
    repeat (n) cycle();
    reset_i = 1'b0;
    cycle();
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    rdy = 1'b1;
    while ((sb1.size() != 0 || sb2.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", (n < budget), 1);
  endtask

  task automatic run_frame();
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v1 = 1'b1; v2 = 1'b1;
      d1 = frame_vec[i].d1; d2 = frame_vec[i].d2;
      cycle();
      check("frm_valid", vo, 2'b11);
      check("frm_d1", q1d, frame_vec[i].d1);
      check("frm_d2", q2d, frame_vec[i].d2);
      check("frm_last", last, frame_vec[i].last);
    end
    v1 = 1'b0; v2 = 1'b0;
    cycle();
    check("frm_done", done, 1);
    check("frm_done_valid", vo, 2'b00);
    cycle();
    check("frm_idle_valid", vo, 2'b00);
    check("frm_idle_done", done, 0);
  endtask

  initial begin
    int x0;
    frame_vec[0] = '{16'h0698, 16'hF105, 1'b0};
    frame_vec[1] = '{16'hF8DD, 16'hF17A, 1'b0};
    frame_vec[2] = '{16'hF31C, 16'hF1A0, 1'b0};
    frame_vec[3] = '{16'h063C, 16'hFA26, 1'b0};
    frame_vec[4] = '{16'h0123, 16'hF11A, 1'b1};
    pre1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    pre2 = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    pat_vec[0] = '{2'b11, 1'b0, 1'b0, 16'h1111, 16'hA001};
    pat_vec[1] = '{2'b11, 1'b1, 1'b0, 16'h2222, 16'hA002};
    pat_vec[2] = '{2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000};
    pat_vec[3] = '{2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000};
    pat_vec[4] = '{2'b11, 1'b0, 1'b0, 16'h3333, 16'hA003};
    pat_vec[5] = '{2'b11, 1'b1, 1'b0, 16'h4444, 16'hA004};

    // Reset: outputs held low while asserted, idle and ready afterwards.
    reset_i = 1'b1;
    cycle();
    cycle();
    check("rst_ready1", r1, 0);
    check("rst_ready2", r2, 0);
    check("rst_valid", vo, 2'b00);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    reset_i = 1'b0;
    cycle();
    check("idle_ready1", r1, 1);
    check("idle_ready2", r2, 1);
    check("idle_valid", vo, 2'b00);
    check("idle_busy", busy, 0);
    check("idle_last", last, 0);

    // Five simultaneous pairs, last on the fifth only.
    run_frame();

    // Stream 2 lags stream 1 by three cycles.
    x0 = xfers;
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v1 = (i < 4);
      d1 = 16'h5000 + W'(i);
      v2 = (i >= 3 && i < 7);
      d2 = 16'h6000 + W'(i);
      cycle();
      if (i == 2) check("skew_ready1_3", r1, 1);
      if (i == 3) check("skew_ready1_full", r1, 0);
    end
    v1 = 1'b0; v2 = 1'b0;
    drain(20);
    check("skew_xfers", xfers - x0, 4);

    // Six stalled cycles with a pair waiting.
    do_reset(1);
    rdy = 1'b0;
    v1 = 1'b1; v2 = 1'b1; d1 = 16'h1234; d2 = 16'hABCD;
    cycle();
    v1 = 1'b0; v2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("hold_valid", vo, 2'b11);
      check("hold_d1", q1d, 16'h1234);
      check("hold_d2", q2d, 16'hABCD);
      check("hold_last", last, 0);
      cycle();
    end
`ifdef SUB_JOIN_PERF_EN
    check("stall_cnt", stall_cnt, 6);
`endif
    rdy = 1'b1;
    cycle();
    drain(10);

    // Reset after two of five pairs, with words still queued.
    do_reset(1);
    rdy = 1'b1;
    v1 = 1'b1; v2 = 1'b1; d1 = 16'h0A01; d2 = 16'h0B01;
    cycle();
    d1 = 16'h0A02; d2 = 16'h0B02;
    cycle();
    v1 = 1'b0; v2 = 1'b0;
    cycle();
    rdy = 1'b0;
    v1 = 1'b1; v2 = 1'b1; d1 = 16'h0A03; d2 = 16'h0B03;
    cycle();
    d1 = 16'h0A04; d2 = 16'h0B04;
    cycle();
    v1 = 1'b0; v2 = 1'b0;
    check("pre_rst_busy", busy, 1);
    do_reset(1);
    check("mid_rst_valid", vo, 2'b00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready1", r1, 1);
    run_frame();

    // FRAME_LEN=2 instance, four pairs preloaded.
    b_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_v1 = 1'b1; b_v2 = 1'b1; b_d1 = pre1[i]; b_d2 = pre2[i];
      cycle();
    end
    b_v1 = 1'b0; b_v2 = 1'b0;
    check("pre_full1", b_r1, 0);
`ifdef SUB_JOIN_PERF_EN
    check("b_stall_cnt", b_stall, 3);
`endif
    b_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("pat_valid", b_vo, pat_vec[i].vo);
      check("pat_last", b_last, pat_vec[i].last);
      check("pat_done", b_done, pat_vec[i].done);
      if (pat_vec[i].vo == 2'b11) begin
        check("pat_d1", b_q1d, pat_vec[i].d1);
        check("pat_d2", b_q2d, pat_vec[i].d2);
      end
      $display("pattern %0d: valid=%b last=%0b done=%0b", i, b_vo, b_last, b_done);
      cycle();
    end
    cycle();
    check("pat_end_busy", b_busy, 0);
    check("pat_end_ready1", b_r1, 1);
    check("pat_end_ready2", b_r2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
